// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI master arbiter: FSM encoding, defaults, word width.
package spi_arbiter_pkg;

    localparam int SPI_WORD_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_GAP_CYCLES     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RESP      = 3'd3,
        ST_ABORT     = 3'd4,
        ST_GAP       = 3'd5
    } arb_state_t;

    // Increment an index, wrapping to zero after modulus-1.
    function automatic int wrap_inc(input int idx, input int modulus);
        if (idx >= modulus - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic w_found;

    // Scan from the pointer upwards (modulo N_REQ) and stop at the first request.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                o_grant[(int'(i_ptr) + k) % N_REQ] = 1'b1;
                o_idx   = PTR_W'((int'(i_ptr) + k) % N_REQ);
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPI master among N_REQ requesters, with start
// handshake, done-edge detection, timeout abort and chip-select demux.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [SPI_WORD_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic                         rsp_err,
    output logic [SPI_WORD_W-1:0]        rsp_data,
    output logic                         spi_start,
    output logic [SPI_WORD_W-1:0]        spi_tx,
    input  logic [SPI_WORD_W-1:0]        spi_rx,
    input  logic                         spi_done,
    input  logic                         spi_busy,
    input  logic                         spi_cs,
    output logic [N_REQ-1:0]             cs_out
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_nxt;
    logic [TIMER_W-1:0]      r_timer;
    logic [TIMER_W-1:0]      w_timer_nxt;
    logic [TIMER_W-1:0]      w_timer_inc;
    logic [N_REQ-1:0]        r_grant;
    logic [N_REQ-1:0]        w_grant_nxt;
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [N_REQ-1:0]        w_rsp_valid_nxt;
    logic                    r_rsp_err;
    logic                    w_rsp_err_nxt;
    logic [SPI_WORD_W-1:0]   r_rsp_data;
    logic [SPI_WORD_W-1:0]   w_rsp_data_nxt;
    logic                    r_spi_start;
    logic                    w_spi_start_nxt;
    logic [SPI_WORD_W-1:0]   r_spi_tx;
    logic [SPI_WORD_W-1:0]   w_spi_tx_nxt;

    logic                    r_done_q;
    logic                    r_done_qq;
    logic                    r_busy_q;
    logic                    w_done_rise;

    logic [N_REQ-1:0]        w_arb_grant;
    logic [PTR_W-1:0]        w_arb_idx;
    logic                    w_arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // The master's status lines move on divided-clock edges derived from clk,
    // so a single register stage is enough before use.
    assign w_done_rise = r_done_q & ~r_done_qq;

    // Phase timer steps up but sticks at all-ones rather than wrapping.
    assign w_timer_inc = (r_timer == TIMER_MAX) ? r_timer : (r_timer + TIMER_W'(1));

    // Capture master status lines and the previous done level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done_q  <= 1'b0;
            r_done_qq <= 1'b0;
            r_busy_q  <= 1'b0;
        end else begin
            r_done_q  <= spi_done;
            r_done_qq <= r_done_q;
            r_busy_q  <= spi_busy;
        end
    end

    // Next-state and next-output decode for the transaction sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_timer_nxt     = r_timer;
        w_grant_nxt     = r_grant;
        w_rsp_valid_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_spi_start_nxt = r_spi_start;
        w_spi_tx_nxt    = r_spi_tx;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_grant_nxt     = w_arb_grant;
                    w_spi_tx_nxt    = req_data[int'(w_arb_idx)*SPI_WORD_W +: SPI_WORD_W];
                    w_timer_nxt     = '0;
                    w_spi_start_nxt = 1'b1;
                    w_ptr_nxt       = PTR_W'(wrap_inc(int'(w_arb_idx), N_REQ));
                    w_state_nxt     = ST_START;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_START: begin
                // Busy is checked first so it wins over a coincident timeout.
                if (r_busy_q) begin
                    w_spi_start_nxt = 1'b0;
                    w_timer_nxt     = '0;
                    w_state_nxt     = ST_WAIT_DONE;
                end else if (r_timer == TO_LAST) begin
                    w_spi_start_nxt = 1'b0;
                    w_state_nxt     = ST_ABORT;
                end else begin
                    w_timer_nxt     = w_timer_inc;
                end
            end
            ST_WAIT_DONE: begin
                // Done is checked first so it wins over a coincident timeout.
                if (w_done_rise) begin
                    w_rsp_data_nxt  = spi_rx;
                    w_state_nxt     = ST_RESP;
                end else if (r_timer == TO_LAST) begin
                    w_state_nxt     = ST_ABORT;
                end else begin
                    w_timer_nxt     = w_timer_inc;
                end
            end
            ST_RESP: begin
                w_rsp_valid_nxt = r_grant;
                w_rsp_err_nxt   = 1'b0;
                w_grant_nxt     = '0;
                w_timer_nxt     = '0;
                w_state_nxt     = ST_GAP;
            end
            ST_ABORT: begin
                w_rsp_valid_nxt = r_grant;
                w_rsp_err_nxt   = 1'b1;
                w_rsp_data_nxt  = '0;
                w_spi_start_nxt = 1'b0;
                w_grant_nxt     = '0;
                w_timer_nxt     = '0;
                w_state_nxt     = ST_GAP;
            end
            ST_GAP: begin
                // Chip selects stay high for GAP_CYCLES; no arbitration here.
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            default: begin
                w_grant_nxt     = '0;
                w_spi_start_nxt = 1'b0;
                w_timer_nxt     = '0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers: pointer, timer, grant, response, master drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_timer     <= '0;
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_spi_start <= 1'b0;
            r_spi_tx    <= '0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_timer     <= w_timer_nxt;
            r_grant     <= w_grant_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_spi_start <= w_spi_start_nxt;
            r_spi_tx    <= w_spi_tx_nxt;
        end
    end

    assign grant     = r_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign spi_start = r_spi_start;
    assign spi_tx    = r_spi_tx;

    // Only the owner sees the master's chip select; the grant register being
    // one-hot guarantees at most one device select is low.
    assign cs_out = ~r_grant | {N_REQ{spi_cs}};

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a behavioural SPI master model.
module tb_spi_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 4096;
    localparam int GAP = 8;

    typedef struct {
        logic [NR-1:0] owner;
        logic [15:0]   data;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [16*NR-1:0] req_data;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_err;
    logic [15:0]     rsp_data;
    logic            spi_start;
    logic [15:0]     spi_tx;
    logic [15:0]     spi_rx;
    logic            spi_done;
    logic            spi_busy;
    logic            spi_cs;
    logic [NR-1:0]   cs_out;

    int n_chk = 0;
    int n_fail = 0;
    int n_rsp = 0;
    int cyc = 0;
    int idle_cnt = 1000;
    int grant_cyc = 0;
    int grants_left = 0;
    logic hold_req = 1'b0;
    logic cs3_low = 1'b0;
    logic [NR-1:0] cur_owner = '0;
    logic [NR-1:0] prev_grant = '0;

    exp_t          rsp_q[$];
    logic [NR-1:0] grant_q[$];

    // master model controls (written by the main process only)
    logic        m_never_busy = 1'b0;
    logic        m_kill = 1'b0;
    int          m_xfer_len = 6;
    int          m_done_len = 2;
    logic [15:0] m_rx_xor = 16'h0000;
    // master model state (written by the model process only)
    logic [15:0] m_tx;
    int          m_done_cyc = 0;

    logic [15:0] words [NR] = '{16'h0F01, 16'h1E12, 16'h2D23, 16'h3C34};

    spi_arbiter #(
        .N_REQ          (NR),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .spi_start (spi_start),
        .spi_tx    (spi_tx),
        .spi_rx    (spi_rx),
        .spi_done  (spi_done),
        .spi_busy  (spi_busy),
        .spi_cs    (spi_cs),
        .cs_out    (cs_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of bench time: sample at negedge, score responses, grants and chip selects.
    task automatic tick();
        exp_t e;
        logic [NR-1:0] eg;
        logic [NR-1:0] exp_cs;
        @(negedge clk);
        if (!reset) begin
            cur_owner  = '0;
            prev_grant = '0;
            idle_cnt   = 1000;
        end else begin
            if (rsp_valid != '0) begin
                n_rsp++;
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.owner));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    if (e.err) begin
                        chk("abort_latency", 32'(cyc - grant_cyc), 32'(TMO + 1));
                        chk("abort_start_low", 32'(spi_start), 32'd0);
                    end else begin
                        chk("done_latency", 32'(cyc - m_done_cyc), 32'd3);
                    end
                end
                if (!hold_req) req = req & ~rsp_valid;
                cur_owner = '0;
            end
            if (grant != '0 && prev_grant == '0) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", 32'(grant), 32'd0);
                end else begin
                    eg = grant_q.pop_front();
                    chk("grant", 32'(grant), 32'(eg));
                    chk("gap_idle", 32'(idle_cnt >= GAP), 32'd1);
                    cur_owner = eg;
                    grant_cyc = cyc;
                    if (hold_req) begin
                        grants_left--;
                        if (grants_left == 0) req = '0;
                    end
                end
            end
            if (grant == '0) idle_cnt++;
            else idle_cnt = 0;
            prev_grant = grant;
            exp_cs = (cur_owner != '0 && spi_cs == 1'b0) ? ~cur_owner : {NR{1'b1}};
            chk("cs_out", 32'(cs_out), 32'(exp_cs));
            if (cs_out[3] == 1'b0) cs3_low = 1'b1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            tick();
            k++;
        end
        chk("rsp_count", 32'(n_rsp), 32'(target));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        ticks(2);
    endtask

    task automatic push(input logic [NR-1:0] owner, input logic [15:0] data, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.err   = err;
        grant_q.push_back(owner);
        rsp_q.push_back(e);
    endtask

    task automatic set_words();
        for (int i = 0; i < NR; i++) req_data[16*i +: 16] = words[i];
    endtask

    // Behavioural SPI master: drives status lines away from clock edges.
    initial begin
        spi_busy = 1'b0;
        spi_done = 1'b0;
        spi_cs   = 1'b1;
        spi_rx   = 16'h0000;
        forever begin
            @(posedge clk); #2;
            if (m_kill) begin
                spi_busy = 1'b0;
                spi_cs   = 1'b1;
                spi_done = 1'b0;
            end else if (reset && spi_start && !m_never_busy) begin
                for (int k = 0; k < 2 && !m_kill; k++) begin @(posedge clk); #2; end
                if (!m_kill) begin
                    m_tx     = spi_tx;
                    spi_busy = 1'b1;
                    spi_cs   = 1'b0;
                    for (int k = 0; k < m_xfer_len && !m_kill; k++) begin @(posedge clk); #2; end
                    if (!m_kill) begin
                        spi_rx     = m_tx ^ m_rx_xor;
                        spi_busy   = 1'b0;
                        spi_cs     = 1'b1;
                        spi_done   = 1'b1;
                        m_done_cyc = cyc;
                        for (int k = 0; k < m_done_len && !m_kill; k++) begin @(posedge clk); #2; end
                        spi_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_tx", 32'(spi_tx), 32'd0);
        chk("rst_cs_out", 32'(cs_out), 32'hF);
        reset = 1'b1;
        ticks(2);

        // single request with loopback
        req_data[47:32] = 16'hA5C3;
        m_rx_xor = 16'h0000;
        push(4'b0100, 16'hA5C3, 1'b0);
        req = 4'b0100;
        wait_rsp(1, 200);
        ticks(20);

        // fairness from pointer 0 with all requests held
        do_reset();
        set_words();
        m_rx_xor = 16'h5A5A;
        for (int t = 0; t < 8; t++) push(4'(1 << (t % 4)), words[t % 4] ^ 16'h5A5A, 1'b0);
        hold_req = 1'b1;
        grants_left = 8;
        req = 4'b1111;
        wait_rsp(9, 800);
        hold_req = 1'b0;
        ticks(20);

        // START timeout, then the next requester is served
        do_reset();
        m_rx_xor = 16'h0000;
        m_never_busy = 1'b1;
        push(4'b0001, 16'h0000, 1'b1);
        push(4'b0010, words[1], 1'b0);
        req = 4'b0011;
        wait_rsp(10, 5000);
        m_never_busy = 1'b0;
        wait_rsp(11, 300);
        ticks(20);

        // done held high for 10 clocks: a single response only
        m_done_len = 10;
        push(4'b0001, words[0], 1'b0);
        req = 4'b0001;
        wait_rsp(12, 300);
        ticks(40);
        chk("done_level_single", 32'(n_rsp), 32'd12);
        m_done_len = 2;

        // reset in the middle of WAIT_DONE
        m_xfer_len = 40;
        grant_q.push_back(4'b0100);
        req = 4'b0100;
        k = 0;
        while (!spi_busy && k < 100) begin tick(); k++; end
        chk("busy_seen", 32'(spi_busy), 32'd1);
        ticks(5);
        m_kill = 1'b1;
        req = 4'b1010;
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_cs_out", 32'(cs_out), 32'hF);
        chk("mid_rst_spi_start", 32'(spi_start), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        ticks(2);
        chk("mid_rst_hold_grant", 32'(grant), 32'd0);
        m_xfer_len = 6;
        m_kill = 1'b0;
        reset = 1'b1;
        push(4'b0010, words[1], 1'b0);
        push(4'b1000, words[3], 1'b0);
        wait_rsp(14, 400);
        ticks(20);

        // request 3 pulsed only during GAP is never served
        push(4'b0001, words[0], 1'b0);
        req = 4'b0001;
        wait_rsp(15, 300);
        cs3_low = 1'b0;
        req = req | 4'b1000;
        ticks(3);
        req = req & 4'b0111;
        ticks(40);
        chk("withdraw_cs3_idle", 32'(cs3_low), 32'd0);
        chk("withdraw_rsp_count", 32'(n_rsp), 32'd15);

        chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
